// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage rv32i pipeline: stage load enables, bubbles, perf counters.
// Latency: control outputs combinational from inputs/state; state and counters update on posedge clk.
// Backpressure: any cache stall or busy mul/div freezes every stage; load-use bubbles ID/EX only.
module pipeline_hazard_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_read,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_br_mispredict,
  input  logic                 ex_muldiv_start,
  input  logic                 muldiv_done,
  output logic                 pc_load,
  output logic                 pc_redirect,
  output logic                 load_if_id,
  output logic                 load_id_ex,
  output logic                 load_ex_mem,
  output logic                 load_mem_wb,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, MULDIV = 2'd1, MD_HOLD = 2'd2} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  logic   if_stall, mem_stall, ext_stall;
  logic   md_busy, gstall, load_use, mispredict_fire;

  assign if_stall  = imem_read & ~imem_resp;
  assign mem_stall = dmem_req & ~dmem_resp;
  assign ext_stall = if_stall | mem_stall;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // A result finishing under a cache stall parks in MD_HOLD so the still-asserted start is not re-issued.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (ex_muldiv_start)
                 state_nxt = muldiv_done ? (ext_stall ? MD_HOLD : RUN) : MULDIV;
      MULDIV:  if (muldiv_done) state_nxt = ext_stall ? MD_HOLD : RUN;
      MD_HOLD: if (!ext_stall) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    md_busy = 1'b0;
    case (state)
      RUN:     md_busy = ex_muldiv_start & ~muldiv_done;
      MULDIV:  md_busy = ~muldiv_done;
      default: md_busy = 1'b0;
    endcase
  end

  assign gstall   = ext_stall | md_busy;
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign mispredict_fire = ~rst & ~gstall & ex_br_mispredict;

  always_comb begin
    pc_load     = 1'b1;
    pc_redirect = 1'b0;
    load_if_id  = 1'b1;
    load_id_ex  = 1'b1;
    load_ex_mem = 1'b1;
    load_mem_wb = 1'b1;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (rst) begin
      pc_load     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (gstall) begin
      pc_load     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
    end else if (ex_br_mispredict) begin
      // Wrong-path ID instruction: its load-use hazard is irrelevant.
      pc_redirect = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use) begin
      pc_load     = 1'b0;
      load_if_id  = 1'b0;
      flush_id_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_load && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      if (mispredict_fire && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboarded bench for pipeline_hazard_ctrl: expected controls/counters queued per driven cycle.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 5;
  localparam logic [CW-1:0] CMAX = '1;

  // {pc_load, pc_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}
  localparam logic [7:0] C_RUN   = 8'b1011_1100;
  localparam logic [7:0] C_STALL = 8'b0000_0000;
  localparam logic [7:0] C_RST   = 8'b0000_0011;
  localparam logic [7:0] C_MISP  = 8'b1111_1111;
  localparam logic [7:0] C_LU    = 8'b0001_1101;

  typedef struct packed {
    logic       rst;
    logic       imem_read, imem_resp, dmem_req, dmem_resp;
    logic [4:0] id_rs1, id_rs2;
    logic       id_uses_rs1, id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read, ex_br_mispredict, ex_muldiv_start, muldiv_done;
  } in_t;

  typedef struct {
    string      tag;
    logic [7:0] ctl;
    logic       cnt_chk;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  logic clk = 1'b0;
  in_t  din;
  logic pc_load, pc_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex;
  logic [CW-1:0] stall_cnt, flush_cnt;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(din.rst),
    .imem_read(din.imem_read), .imem_resp(din.imem_resp),
    .dmem_req(din.dmem_req), .dmem_resp(din.dmem_resp),
    .id_rs1(din.id_rs1), .id_rs2(din.id_rs2),
    .id_uses_rs1(din.id_uses_rs1), .id_uses_rs2(din.id_uses_rs2),
    .ex_rd(din.ex_rd), .ex_mem_read(din.ex_mem_read),
    .ex_br_mispredict(din.ex_br_mispredict),
    .ex_muldiv_start(din.ex_muldiv_start), .muldiv_done(din.muldiv_done),
    .pc_load(pc_load), .pc_redirect(pc_redirect),
    .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle and queue what the DUT must show during it.
  task automatic cyc(input in_t v, input logic [7:0] ectl, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    din = v;
    e.tag = tag;
    e.ctl = ectl;
    e.cnt_chk = ~v.rst;
    e.stall = m_stall;
    e.flush = m_flush;
    sb.push_back(e);
    if (v.rst) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (!ectl[7] && m_stall != CMAX) m_stall = m_stall + 1'b1;
      if (ectl[6] && m_flush != CMAX) m_flush = m_flush + 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".ctl"},
          {24'd0, pc_load, pc_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex}, {24'd0, e.ctl});
      if (e.cnt_chk) begin
        chk({e.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.stall));
        chk({e.tag, ".flush_cnt"}, 32'(flush_cnt), 32'(e.flush));
      end
    end
  end

  initial begin
    in_t v;
    din = '0;
    din.rst = 1'b1;

    v = '0; v.rst = 1'b1;
    cyc(v, C_RST, "reset0");
    cyc(v, C_RST, "reset1");
    v = '0;
    cyc(v, C_RUN, "idle0");
    cyc(v, C_RUN, "idle1");

    // Load-use on rs1 and rs2, and the non-hazard variants.
    v = '0; v.ex_mem_read = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_uses_rs1 = 1;
    cyc(v, C_LU, "lu_rs1");
    v = '0;
    cyc(v, C_RUN, "after_lu");
    v = '0; v.ex_mem_read = 1; v.ex_rd = 7; v.id_rs2 = 7; v.id_uses_rs2 = 1; v.id_rs1 = 7;
    cyc(v, C_LU, "lu_rs2");
    v = '0; v.ex_mem_read = 1; v.ex_rd = 7; v.id_rs1 = 7; v.id_uses_rs1 = 0;
    cyc(v, C_RUN, "lu_unused_rs1");
    v = '0; v.ex_mem_read = 1; v.ex_rd = 0; v.id_rs1 = 0; v.id_uses_rs1 = 1;
    cyc(v, C_RUN, "lu_x0");
    v = '0; v.ex_mem_read = 0; v.ex_rd = 9; v.id_rs1 = 9; v.id_uses_rs1 = 1;
    cyc(v, C_RUN, "no_load");

    // Mispredict held across an I-cache stall.
    v = '0; v.ex_br_mispredict = 1; v.imem_read = 1;
    for (int i = 0; i < 3; i++) cyc(v, C_STALL, "misp_if_stall");
    v.imem_resp = 1;
    cyc(v, C_MISP, "misp_apply");
    v = '0;
    cyc(v, C_RUN, "after_misp");

    v = '0; v.ex_br_mispredict = 1; v.ex_mem_read = 1; v.ex_rd = 3; v.id_rs1 = 3; v.id_uses_rs1 = 1;
    cyc(v, C_MISP, "misp_over_lu");

    v = '0; v.dmem_req = 1;
    cyc(v, C_STALL, "dmem_wait");
    v.dmem_resp = 1;
    cyc(v, C_RUN, "dmem_resp");

    // Mul/div: 4 busy cycles then done.
    v = '0; v.ex_muldiv_start = 1;
    for (int i = 0; i < 4; i++) cyc(v, C_STALL, "md_busy");
    v.muldiv_done = 1;
    cyc(v, C_RUN, "md_done");
    v = '0;
    cyc(v, C_RUN, "md_after");

    // Done under mem stall: held result, start ignored, advance when stall clears.
    v = '0; v.ex_muldiv_start = 1;
    cyc(v, C_STALL, "mdh_busy0");
    cyc(v, C_STALL, "mdh_busy1");
    v.muldiv_done = 1; v.dmem_req = 1;
    cyc(v, C_STALL, "mdh_done_stall");
    v.muldiv_done = 0;
    cyc(v, C_STALL, "mdh_hold0");
    cyc(v, C_STALL, "mdh_hold1");
    v.dmem_resp = 1;
    cyc(v, C_RUN, "mdh_release");
    v = '0;
    cyc(v, C_RUN, "mdh_after");

    v = '0; v.muldiv_done = 1;
    cyc(v, C_RUN, "stray_done");
    v = '0; v.ex_muldiv_start = 1; v.muldiv_done = 1;
    cyc(v, C_RUN, "md_1cycle");
    v = '0;
    cyc(v, C_RUN, "md_1cycle_after");

    // Reset in the middle of a mul/div.
    v = '0; v.ex_muldiv_start = 1;
    cyc(v, C_STALL, "rst_md0");
    cyc(v, C_STALL, "rst_md1");
    v.rst = 1;
    cyc(v, C_RST, "rst_in_md");
    v = '0;
    cyc(v, C_RUN, "rst_md_clear");
    cyc(v, C_RUN, "rst_md_clear2");

    // Counter saturation.
    v = '0; v.dmem_req = 1;
    for (int i = 0; i < 34; i++) cyc(v, C_STALL, "sat_stall");
    v = '0;
    cyc(v, C_RUN, "sat_after");
    cyc(v, C_RUN, "sat_after2");

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    chk("stall_saturated", 32'(stall_cnt), 32'(CMAX));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
